serial_word_collector: RTL and testbench
========================================

// Module: serial_word_collector
// PURPOSE
// - Upstream feeder for the parameterized XNOR parity-reduction stage.
// - Accepts a serial bit stream one bit per handshake and assembles DATA_WIDTH-bit words, LSB first.
// - Presents each completed word on a valid/ready output port. The downstream parity tree consumes it.
// - Optionally receives and checks a trailing even-parity bit per frame.
// PARAMETERS
// - DATA_WIDTH  default 8  bits per word; legal range 1..64.
// - CNT_WIDTH   default $clog2(DATA_WIDTH+1)  bit-counter width; derived, do not override.
// PORTS
// - clock        input   1           rising-edge clock; single clock domain.
// - reset        input   1           asynchronous, active-high reset.
// - serialBit    input   1           incoming data bit.
// - bitValid     input   1           serialBit is valid this cycle.
// - bitReady     output  1           collector accepts a bit this cycle.
// - frameAbort   input   1           discard the partial frame and return to COLLECT.
// - wordData     output  DATA_WIDTH  assembled word; bit 0 = first bit received.
// - wordValid    output  1           wordData is stable and complete.
// - wordReady    input   1           downstream consumes the word.
// - parityError  output  1           parity check failed for the current word (PARITY_BIT_EN only).
// - bitCount     output  CNT_WIDTH   data bits accepted in the current frame.
// BEHAVIOUR
// - Reset (async, active-high):
//   - state=COLLECT; bitCount=0; wordData=0; wordValid=0; bitReady=1; parityError=0.
// - States: COLLECT, PARITY (macro only), HOLD.
// - Bit acceptance: a bit is accepted when bitValid && bitReady at the rising clock edge.
// - COLLECT:
//   - bitReady=1.
//   - On accept: wordData[bitCount] <= serialBit and bitCount <= bitCount+1.
//   - On the accept where bitCount==DATA_WIDTH-1: go to PARITY if PARITY_BIT_EN is defined, else go to HOLD.
// - PARITY:
//   - bitReady=1.
//   - On accept: parityError <= ^{serialBit, wordData}, i.e. the inverse of the XNOR reduction; then go to HOLD.
//   - Even parity: the total count of ones, including the parity bit, must be even.
// - HOLD:
//   - bitReady=0 and wordValid=1.
//   - wordData and parityError are held constant.
//   - When wordValid && wordReady: bitCount <= 0, wordValid <= 0, parityError <= 0, and go to COLLECT.
// - Latency: wordValid rises exactly one cycle after the final bit is accepted.
// - Back-to-back frames: one bubble cycle after the handshake. bitReady is 0 in the handshake cycle, so no bit of the next frame is accepted in that cycle.
// - frameAbort (sampled at the clock edge), in COLLECT or PARITY:
//   - bitCount <= 0 and the next state is COLLECT.
//   - wordData is not cleared; it is stale and ignored.
//   - frameAbort wins over a simultaneous accepted bit; that bit is dropped.
// - frameAbort in HOLD: ignored; the completed word must be consumed through the handshake.
// - Stalls:
//   - bitValid low in COLLECT or PARITY: no state change; no timeout.
//   - wordReady may be asserted early; it has no effect outside HOLD.
// - DATA_WIDTH=1: every accepted bit completes a word.
// - bitCount never exceeds DATA_WIDTH; it reads DATA_WIDTH while in PARITY and HOLD.
// - Reset mid-frame or in HOLD: all state and outputs return immediately to their reset values.
// CONFIGURATION
// - PARITY_BIT_EN defined:
//   - Each frame is DATA_WIDTH data bits plus one parity bit, and the PARITY state exists.
//   - parityError is valid while wordValid=1.
// - PARITY_BIT_EN undefined:
//   - Each frame is DATA_WIDTH bits; the PARITY state and its logic are not built.
//   - parityError is tied to 0.
// TESTING  (DATA_WIDTH=8)
// 1. Reset, then send bits 1,0,1,1,0,0,1,0 with bitValid=1 and wordReady=0.
//    -> wordValid=1 one cycle after the 8th bit; wordData=8'h4D; bitReady=0; word held for 5 idle cycles.
// 2. From scenario 1, assert wordReady for 1 cycle, then send the next frame immediately.
//    -> wordValid=0 the next cycle; bitCount=0; the first bit is accepted only after the 1-cycle bubble.
// 3. Send 5 bits, then assert frameAbort together with bitValid=1, then send 8 bits of 8'hFF.
//    -> the aborted bit is dropped; bitCount=0 after the abort; then wordData=8'hFF.
// 4. PARITY_BIT_EN: send 8'h4D (four ones) followed by parity bit 0 -> parityError=0.
//    Then send 8'h4D followed by parity bit 1 -> parityError=1 while wordValid=1.
// 5. Assert reset asynchronously mid-frame (bitCount=3) and in HOLD.
//    -> outputs go to reset values without waiting for a clock edge.
//    -> the first frame after release assembles correctly.
// 6. Random bitValid gaps (about 50%) and random wordReady over 200 frames, checked against a reference model.
//    -> no lost, duplicated or reordered bits; no wordData change while wordValid=1.

Source files
------------

// File: rtl/serial_word_collector.sv
// Serial-to-parallel word collector (LSB first) with valid/ready word output.
// Define PARITY_BIT_EN to receive and check a trailing even-parity bit per frame.
module serial_word_collector #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  serialBit,
    input  logic                  bitValid,
    output logic                  bitReady,
    input  logic                  frameAbort,
    output logic [DATA_WIDTH-1:0] wordData,
    output logic                  wordValid,
    input  logic                  wordReady,
    output logic                  parityError,
    output logic [CNT_WIDTH-1:0]  bitCount
);

    // state   | meaning
    // COLLECT | accepting data bits into wordData
    // PARITY  | waiting for the trailing parity bit
    // HOLD    | word presented on wordValid until consumed
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        PARITY  = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t                state_q;
    logic [CNT_WIDTH-1:0]  bit_cnt_q;
    logic [DATA_WIDTH-1:0] word_q;
    logic [DATA_WIDTH-1:0] word_d;
    logic                  word_valid_q;
    logic                  bit_ready_q;
    logic                  accept;
    logic                  last_bit;

    assign accept   = bitValid && bit_ready_q;
    assign last_bit = (bit_cnt_q == CNT_WIDTH'(DATA_WIDTH - 1));

    always_comb begin
        word_d = word_q;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (bit_cnt_q == CNT_WIDTH'(i)) begin
                word_d[i] = serialBit;
            end
        end
    end

`ifdef PARITY_BIT_EN
    logic parity_err_q;
    assign parityError = parity_err_q;
`else
    assign parityError = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= COLLECT;
            bit_cnt_q    <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            bit_ready_q  <= 1'b1;
`ifdef PARITY_BIT_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                COLLECT: begin
                    // Abort takes priority; a bit arriving with it is dropped.
                    if (frameAbort) begin
                        bit_cnt_q <= '0;
                    end else if (accept) begin
                        word_q    <= word_d;
                        bit_cnt_q <= bit_cnt_q + CNT_WIDTH'(1);
                        if (last_bit) begin
`ifdef PARITY_BIT_EN
                            state_q      <= PARITY;
`else
                            state_q      <= HOLD;
                            bit_ready_q  <= 1'b0;
                            word_valid_q <= 1'b1;
`endif
                        end
                    end
                end
`ifdef PARITY_BIT_EN
                PARITY: begin
                    if (frameAbort) begin
                        bit_cnt_q <= '0;
                        state_q   <= COLLECT;
                    end else if (accept) begin
                        parity_err_q <= ^{serialBit, word_q};
                        state_q      <= HOLD;
                        bit_ready_q  <= 1'b0;
                        word_valid_q <= 1'b1;
                    end
                end
`endif
                HOLD: begin
                    if (wordReady) begin
                        bit_cnt_q    <= '0;
                        word_valid_q <= 1'b0;
                        bit_ready_q  <= 1'b1;
                        state_q      <= COLLECT;
`ifdef PARITY_BIT_EN
                        parity_err_q <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q      <= COLLECT;
                    bit_cnt_q    <= '0;
                    word_valid_q <= 1'b0;
                    bit_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bitReady  = bit_ready_q;
    assign wordData  = word_q;
    assign wordValid = word_valid_q;
    assign bitCount  = bit_cnt_q;

endmodule

// File: tb/tb_serial_word_collector.sv
// Directed and randomized self-checking bench for serial_word_collector (DATA_WIDTH=8).
// Honours PARITY_BIT_EN the same way the design does.
module tb_serial_word_collector;

    localparam int DW = 8;
    localparam int CW = $clog2(DW + 1);
`ifdef PARITY_BIT_EN
    localparam int NB = DW + 1;
`else
    localparam int NB = DW;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          serialBit;
    logic          bitValid;
    logic          bitReady;
    logic          frameAbort;
    logic [DW-1:0] wordData;
    logic          wordValid;
    logic          wordReady;
    logic          parityError;
    logic [CW-1:0] bitCount;

    int checks = 0;
    int errors = 0;

    serial_word_collector #(.DATA_WIDTH(DW)) dut (
        .clock      (clock),
        .reset      (reset),
        .serialBit  (serialBit),
        .bitValid   (bitValid),
        .bitReady   (bitReady),
        .frameAbort (frameAbort),
        .wordData   (wordData),
        .wordValid  (wordValid),
        .wordReady  (wordReady),
        .parityError(parityError),
        .bitCount   (bitCount)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Sends one complete frame with bitValid held high; parity bit only when built in.
    task automatic drive_word(input logic [DW-1:0] w, input logic pbit);
        for (int i = 0; i < DW; i++) begin
            bitValid  = 1'b1;
            serialBit = w[i];
            tick();
        end
`ifdef PARITY_BIT_EN
        serialBit = pbit;
        tick();
`endif
        bitValid  = 1'b0;
        serialBit = pbit;
    endtask

    task automatic test_reset();
        reset = 1'b1; serialBit = 1'b0; bitValid = 1'b0; frameAbort = 1'b0; wordReady = 1'b0;
        #2;
        checks++; if (wordValid !== 1'b0) begin errors++; $display("FAIL reset_wordValid: got %b expected 0", wordValid); end
        checks++; if (bitReady !== 1'b1) begin errors++; $display("FAIL reset_bitReady: got %b expected 1", bitReady); end
        checks++; if (bitCount !== 4'd0) begin errors++; $display("FAIL reset_bitCount: got %0d expected 0", bitCount); end
        checks++; if (wordData !== 8'h00) begin errors++; $display("FAIL reset_wordData: got %h expected 00", wordData); end
        checks++; if (parityError !== 1'b0) begin errors++; $display("FAIL reset_parityError: got %b expected 0", parityError); end
        #1 reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] bits;
        bits = 8'h4D;
        for (int i = 0; i < DW; i++) begin
            bitValid  = 1'b1;
            serialBit = bits[i];
            tick();
            if (i == DW - 2) begin
                checks++; if (bitCount !== 4'd7) begin errors++; $display("FAIL basic_count7: got %0d expected 7", bitCount); end
                checks++; if (wordValid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", wordValid); end
            end
        end
`ifdef PARITY_BIT_EN
        checks++; if (wordValid !== 1'b0) begin errors++; $display("FAIL basic_valid_before_parity: got %b expected 0", wordValid); end
        serialBit = 1'b0;
        tick();
`endif
        bitValid = 1'b0;
        checks++; if (wordValid !== 1'b1) begin errors++; $display("FAIL basic_wordValid: got %b expected 1", wordValid); end
        checks++; if (wordData !== 8'h4D) begin errors++; $display("FAIL basic_wordData: got %h expected 4d", wordData); end
        checks++; if (bitReady !== 1'b0) begin errors++; $display("FAIL basic_bitReady: got %b expected 0", bitReady); end
        checks++; if (bitCount !== 4'd8) begin errors++; $display("FAIL basic_bitCount: got %0d expected 8", bitCount); end
        checks++; if (parityError !== 1'b0) begin errors++; $display("FAIL basic_parityError: got %b expected 0", parityError); end
        for (int c = 0; c < 5; c++) begin
            bitValid  = 1'b1;
            serialBit = c[0];
            tick();
            checks++; if (wordValid !== 1'b1 || wordData !== 8'h4D) begin
                errors++; $display("FAIL basic_hold: got valid=%b data=%h expected valid=1 data=4d", wordValid, wordData);
            end
        end
        bitValid = 1'b0;
    endtask

    task automatic test_back_to_back();
        // First bit of the next frame is presented during the handshake cycle and must not be taken.
        wordReady = 1'b1; bitValid = 1'b1; serialBit = 1'b1;
        tick();
        wordReady = 1'b0;
        checks++; if (wordValid !== 1'b0) begin errors++; $display("FAIL b2b_wordValid: got %b expected 0", wordValid); end
        checks++; if (bitCount !== 4'd0) begin errors++; $display("FAIL b2b_bitCount: got %0d expected 0", bitCount); end
        checks++; if (bitReady !== 1'b1) begin errors++; $display("FAIL b2b_bitReady: got %b expected 1", bitReady); end
        tick();
        checks++; if (bitCount !== 4'd1) begin errors++; $display("FAIL b2b_first_accept: got %0d expected 1", bitCount); end
        bitValid = 1'b0;
        for (int i = 1; i < DW; i++) begin
            bitValid  = 1'b1;
            serialBit = (8'hA5 >> i) & 8'h01;
            tick();
        end
`ifdef PARITY_BIT_EN
        serialBit = 1'b0;
        tick();
`endif
        bitValid = 1'b0;
        checks++; if (wordData !== 8'hA5) begin errors++; $display("FAIL b2b_wordData: got %h expected a5", wordData); end
        checks++; if (wordValid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b expected 1", wordValid); end
        wordReady = 1'b1;
        tick();
        wordReady = 1'b0;
        checks++; if (wordValid !== 1'b0) begin errors++; $display("FAIL b2b_consume: got %b expected 0", wordValid); end
    endtask

    task automatic test_abort();
        logic [4:0] pre;
        pre = 5'b10011;
        for (int i = 0; i < 5; i++) begin
            bitValid  = 1'b1;
            serialBit = pre[i];
            tick();
        end
        checks++; if (bitCount !== 4'd5) begin errors++; $display("FAIL abort_pre_count: got %0d expected 5", bitCount); end
        frameAbort = 1'b1; serialBit = 1'b1; bitValid = 1'b1;
        tick();
        frameAbort = 1'b0; bitValid = 1'b0;
        checks++; if (bitCount !== 4'd0) begin errors++; $display("FAIL abort_count: got %0d expected 0", bitCount); end
        checks++; if (wordValid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b expected 0", wordValid); end
        drive_word(8'hFF, 1'b0);
        checks++; if (wordData !== 8'hFF) begin errors++; $display("FAIL abort_wordData: got %h expected ff", wordData); end
        checks++; if (wordValid !== 1'b1) begin errors++; $display("FAIL abort_word_valid: got %b expected 1", wordValid); end
        frameAbort = 1'b1;
        tick();
        frameAbort = 1'b0;
        checks++; if (wordValid !== 1'b1 || bitCount !== 4'd8) begin
            errors++; $display("FAIL abort_in_hold: got valid=%b count=%0d expected valid=1 count=8", wordValid, bitCount);
        end
        wordReady = 1'b1;
        tick();
        wordReady = 1'b0;
`ifdef PARITY_BIT_EN
        for (int i = 0; i < DW; i++) begin
            bitValid = 1'b1; serialBit = 1'b0;
            tick();
        end
        bitValid = 1'b0;
        checks++; if (bitCount !== 4'd8 || wordValid !== 1'b0) begin
            errors++; $display("FAIL abort_parity_pre: got count=%0d valid=%b expected count=8 valid=0", bitCount, wordValid);
        end
        frameAbort = 1'b1;
        tick();
        frameAbort = 1'b0;
        checks++; if (bitCount !== 4'd0 || wordValid !== 1'b0) begin
            errors++; $display("FAIL abort_in_parity: got count=%0d valid=%b expected count=0 valid=0", bitCount, wordValid);
        end
`endif
    endtask

`ifdef PARITY_BIT_EN
    task automatic test_parity();
        drive_word(8'h4D, 1'b0);
        checks++; if (wordValid !== 1'b1 || parityError !== 1'b0) begin
            errors++; $display("FAIL parity_good: got valid=%b perr=%b expected valid=1 perr=0", wordValid, parityError);
        end
        wordReady = 1'b1; tick(); wordReady = 1'b0;
        drive_word(8'h4D, 1'b1);
        checks++; if (wordValid !== 1'b1 || parityError !== 1'b1) begin
            errors++; $display("FAIL parity_bad: got valid=%b perr=%b expected valid=1 perr=1", wordValid, parityError);
        end
        tick();
        checks++; if (parityError !== 1'b1) begin errors++; $display("FAIL parity_bad_hold: got %b expected 1", parityError); end
        wordReady = 1'b1; tick(); wordReady = 1'b0;
        checks++; if (parityError !== 1'b0) begin errors++; $display("FAIL parity_clear: got %b expected 0", parityError); end
    endtask
`endif

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            bitValid = 1'b1; serialBit = i[0];
            tick();
        end
        bitValid = 1'b0;
        checks++; if (bitCount !== 4'd3) begin errors++; $display("FAIL arst_pre_count: got %0d expected 3", bitCount); end
        #2 reset = 1'b1;
        #1;
        checks++; if (bitCount !== 4'd0 || bitReady !== 1'b1) begin
            errors++; $display("FAIL arst_mid_frame: got count=%0d ready=%b expected count=0 ready=1", bitCount, bitReady);
        end
        checks++; if (wordData !== 8'h00) begin errors++; $display("FAIL arst_mid_data: got %h expected 00", wordData); end
        #1 reset = 1'b0;
        tick();
        drive_word(8'h3C, 1'b0);
        checks++; if (wordValid !== 1'b1 || wordData !== 8'h3C) begin
            errors++; $display("FAIL arst_pre_hold: got valid=%b data=%h expected valid=1 data=3c", wordValid, wordData);
        end
        #2 reset = 1'b1;
        #1;
        checks++; if (wordValid !== 1'b0 || wordData !== 8'h00) begin
            errors++; $display("FAIL arst_hold: got valid=%b data=%h expected valid=0 data=00", wordValid, wordData);
        end
        checks++; if (bitReady !== 1'b1 || bitCount !== 4'd0) begin
            errors++; $display("FAIL arst_hold_ctrl: got ready=%b count=%0d expected ready=1 count=0", bitReady, bitCount);
        end
        #1 reset = 1'b0;
        tick();
        drive_word(8'hC3, 1'b0);
        checks++; if (wordValid !== 1'b1 || wordData !== 8'hC3) begin
            errors++; $display("FAIL arst_after: got valid=%b data=%h expected valid=1 data=c3", wordValid, wordData);
        end
        wordReady = 1'b1; tick(); wordReady = 1'b0;
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_q[$];
        logic          exp_p[$];
        int            got;
        got = 0;
        fork
            begin
                for (int f = 0; f < 200; f++) begin
                    logic [DW-1:0] w;
                    logic          pb;
                    w  = DW'($urandom);
                    pb = 1'($urandom);
                    exp_q.push_back(w);
`ifdef PARITY_BIT_EN
                    exp_p.push_back(^{pb, w});
`else
                    exp_p.push_back(1'b0);
`endif
                    for (int i = 0; i < NB; i++) begin
                        logic accepted;
                        int   guard;
                        accepted = 1'b0;
                        guard    = 0;
                        while (!accepted) begin
                            bitValid  = ($urandom_range(0, 1) == 1);
                            serialBit = (i < DW) ? w[i] : pb;
                            accepted  = bitValid && bitReady;
                            tick();
                            guard++;
                            if (guard > 1000) begin
                                $display("FAIL rand_bit_timeout: frame %0d bit %0d not accepted within 1000 cycles", f, i);
                                $fatal(1, "bit acceptance timeout");
                            end
                        end
                    end
                end
                bitValid = 1'b0;
            end
            begin
                int cyc;
                cyc = 0;
                while (got < 200 && cyc < 30000) begin
                    wordReady = ($urandom_range(0, 1) == 1);
                    if (wordValid) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++; $display("FAIL rand_unexpected: got word %h expected none", wordData);
                        end else if (wordData !== exp_q[0] || parityError !== exp_p[0]) begin
                            errors++; $display("FAIL rand_word %0d: got data=%h perr=%b expected data=%h perr=%b",
                                               got, wordData, parityError, exp_q[0], exp_p[0]);
                        end
                        if (wordReady && exp_q.size() != 0) begin
                            void'(exp_q.pop_front());
                            void'(exp_p.pop_front());
                            got++;
                        end
                    end
                    tick();
                    cyc++;
                end
                wordReady = 1'b0;
                checks++;
                if (got != 200) begin
                    errors++; $display("FAIL rand_count: got %0d words expected 200", got);
                end
            end
        join
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_abort();
`ifdef PARITY_BIT_EN
        test_parity();
`endif
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
